// File: rtl/sample_serializer.sv
// sample_serializer: output stage of the synth audio path. Samples from the
// echo stage are buffered in a small FIFO and serialized as a mono
// left-justified frame (bclk / lrck / sdata). The FIFO paces the upstream
// chain with one-cycle generate_next requests.
module sample_serializer #(
  parameter int FIFO_DEPTH = 4,
  parameter int BCLK_DIV   = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [15:0]                 sample_in,
  input  logic                        in_ready,
  output logic                        generate_next,
  output logic                        bclk,
  output logic                        lrck,
  output logic                        sdata,
  output logic [$clog2(FIFO_DEPTH):0] fill,
  output logic                        overflow,
  output logic                        underflow
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int FILL_W = PTR_W + 1;
  localparam int DIV_W  = $clog2(BCLK_DIV);
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(BCLK_DIV - 1);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(FIFO_DEPTH);

  logic signed [15:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [DIV_W-1:0]   div_cnt;
  logic [4:0]         bit_idx;
  logic signed [15:0] shreg;
  logic signed [15:0] held;
  logic               pending;

  logic bclk_fall;
  logic frame_start;
  logic right_start;
  logic full;
  logic pop;
  logic push;
  logic drop;

  // Frame events happen on the clk edge where bclk goes 1->0.
  assign bclk_fall   = (div_cnt == DIV_LAST) && bclk;
  assign frame_start = bclk_fall && (bit_idx == 5'd31);
  assign right_start = bclk_fall && (bit_idx == 5'd15);
  assign full        = (fill == FILL_MAX);
  // A full FIFO still accepts a sample when the frame start drains one.
  assign pop         = frame_start && (fill != '0);
  assign push        = in_ready && (!full || pop);
  assign drop        = in_ready && !push;

  assign lrck  = bit_idx[4];
  assign sdata = shreg[15];

  // Bit clock divider and bit index within the 32-bit frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt <= '0;
      bclk    <= 1'b0;
      bit_idx <= '0;
    end else begin
      if (div_cnt == DIV_LAST) begin
        div_cnt <= '0;
        bclk    <= ~bclk;
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
      if (bclk_fall) begin
        bit_idx <= bit_idx + 5'd1;
      end
    end
  end

  // Shift register: load at frame start, reload for the right half, else shift.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shreg     <= '0;
      held      <= '0;
      underflow <= 1'b0;
    end else if (frame_start) begin
      if (pop) begin
        held  <= mem[rd_ptr];
        shreg <= mem[rd_ptr];
      end else begin
        shreg     <= held;
        underflow <= 1'b1;
      end
    end else if (right_start) begin
      shreg <= held;
    end else if (bclk_fall) begin
      shreg <= {shreg[14:0], 1'b0};
    end
  end

  // FIFO storage; contents are meaningless until pointed at, so no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= sample_in;
    end
  end

  // FIFO pointers, occupancy and sticky overflow.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fill     <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push && !pop) begin
        fill <= fill + FILL_W'(1);
      end else if (pop && !push) begin
        fill <= fill - FILL_W'(1);
      end
      if (drop) begin
        overflow <= 1'b1;
      end
    end
  end

  // Upstream request: one outstanding pulse at a time while there is room.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending       <= 1'b0;
      generate_next <= 1'b0;
    end else begin
      if (generate_next) begin
        pending <= 1'b1;
      end else if (in_ready) begin
        pending <= 1'b0;
      end
      generate_next <= !pending && !full && !generate_next;
    end
  end

endmodule

// File: tb/tb_sample_serializer.sv
// Bench for sample_serializer (FIFO_DEPTH=4, BCLK_DIV=2) with a queue-based
// reference model derived from edge counts since reset release.
module tb_sample_serializer;

  localparam int DEPTH = 4;
  localparam int DIV   = 2;
  localparam int FRAME = 64 * DIV;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] sample_in = '0;
  logic        in_ready = 1'b0;
  logic        generate_next;
  logic        bclk;
  logic        lrck;
  logic        sdata;
  logic [2:0]  fill;
  logic        overflow;
  logic        underflow;

  sample_serializer #(.FIFO_DEPTH(DEPTH), .BCLK_DIV(DIV)) dut (
    .clk          (clk),
    .reset        (reset),
    .sample_in    (sample_in),
    .in_ready     (in_ready),
    .generate_next(generate_next),
    .bclk         (bclk),
    .lrck         (lrck),
    .sdata        (sdata),
    .fill         (fill),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // reference model state
  int unsigned m_n;
  logic [15:0] m_q[$];
  logic [15:0] m_cur;
  bit          m_gen, m_pend, m_ovf, m_unf;

  // responder configuration
  bit          auto_en = 0;
  bit          stray_en = 0;
  bit          rand_val = 0;
  int          resp_left = 0;
  int          wait_cnt = 0;
  int          dly_min = 1;
  int          dly_max = 1;
  logic [15:0] fixed_val = '0;
  logic [15:0] rand_or = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_n = 0;
    m_q.delete();
    m_cur = '0;
    m_gen = 0;
    m_pend = 0;
    m_ovf = 0;
    m_unf = 0;
  endtask

  // One rising edge of the model; inputs are those held across the edge.
  task automatic model_edge();
    int sz;
    bit fstart, pop, new_gen;
    if (!reset) begin
      model_reset();
      return;
    end
    sz = m_q.size();
    m_n++;
    fstart = (m_n % FRAME) == 0;
    pop = fstart && (sz > 0);
    new_gen = !m_pend && (sz < DEPTH) && !m_gen;
    if (fstart) begin
      if (sz > 0) m_cur = m_q.pop_front();
      else m_unf = 1;
    end
    if (in_ready) begin
      if (sz < DEPTH || pop) m_q.push_back(sample_in);
      else m_ovf = 1;
    end
    m_pend = m_gen ? 1'b1 : (in_ready ? 1'b0 : m_pend);
    m_gen = new_gen;
  endtask

  // Every-cycle comparison of all outputs against the model.
  task automatic compare_outputs();
    int idx;
    idx = int'((m_n / DIV) / 2) % 32;
    check("bclk", bclk, (m_n / DIV) % 2);
    check("lrck", lrck, idx / 16);
    check("sdata", sdata, m_cur[15 - (idx % 16)]);
    check("fill", fill, m_q.size());
    check("generate_next", generate_next, m_gen);
    check("overflow", overflow, m_ovf);
    check("underflow", underflow, m_unf);
  endtask

  // One clk cycle: model update at the edge, drive at +1, compare at negedge.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    in_ready = 1'b0;
    if (auto_en) begin
      if (wait_cnt > 0) begin
        wait_cnt--;
        if (wait_cnt == 0) begin
          in_ready = 1'b1;
          sample_in = rand_val ? (16'($urandom) | rand_or) : fixed_val;
          if (resp_left > 0) resp_left--;
        end
      end
      if (generate_next && resp_left != 0)
        wait_cnt = int'($urandom_range(dly_max, dly_min));
    end
    if (stray_en && !in_ready && !generate_next && $urandom_range(15, 0) == 0) begin
      in_ready = 1'b1;
      sample_in = 16'($urandom);
    end
    @(negedge clk);
    compare_outputs();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    model_reset();
    in_ready = 1'b0;
    sample_in = '0;
    auto_en = 0;
    stray_en = 0;
    wait_cnt = 0;
    repeat (3) step();
    check("rst_outputs", {generate_next, bclk, lrck, sdata, overflow, underflow}, 0);
    check("rst_fill", fill, 0);
    reset = 1'b1;
  endtask

  task automatic wait_frame(input int limit, output bit ok);
    ok = 0;
    for (int i = 0; i < limit; i++) begin
      if (m_n > 0 && (m_n % FRAME) == 0) begin
        ok = 1;
        return;
      end
      step();
    end
  endtask

  task automatic capture_frame(output logic [31:0] bits, output logic [31:0] lr);
    bit ok;
    bits = '0;
    lr = '0;
    wait_frame(4 * FRAME, ok);
    if (!ok) check("frame_timeout", 1, 0);
    for (int b = 0; b < 32; b++) begin
      bits = {bits[30:0], sdata};
      lr = {lr[30:0], lrck};
      repeat (2 * DIV) step();
    end
  endtask

  initial begin
    logic [31:0] bits, lr;
    logic any_hi;
    bit ok;
    int guard;

    #1;
    // ---------------- reset and single sample ----------------
    do_reset();
    auto_en = 1; resp_left = 1; dly_min = 1; dly_max = 1;
    rand_val = 0; fixed_val = 16'hA5C3;
    step();
    check("first_request", generate_next, 1);
    step();
    check("request_one_cycle", generate_next, 0);
    check("fill_before_push", fill, 0);
    step();
    check("fill_after_push", fill, 1);
    any_hi = 0;
    while (m_n < FRAME) begin
      step();
      if (m_n < FRAME) any_hi = any_hi | sdata;
    end
    check("frame0_zero", any_hi, 0);
    check("pop_empties", fill, 0);
    capture_frame(bits, lr);
    check("frame1_bits", bits, 32'hA5C3A5C3);
    check("frame1_lrck", lr, 32'h0000FFFF);

    // ---------------- underflow and mid-frame reset ----------------
    do_reset();
    auto_en = 1; resp_left = 1; dly_min = 2; dly_max = 2;
    rand_val = 0; fixed_val = 16'h8001;
    wait_frame(2 * FRAME, ok);
    check("underflow_clear_f1", underflow, 0);
    capture_frame(bits, lr);
    check("uf_frame1", bits, 32'h80018001);
    check("underflow_set_f2", underflow, 1);
    capture_frame(bits, lr);
    check("uf_frame2", bits, 32'h80018001);
    guard = 0;
    while ((int'((m_n / DIV) / 2) % 32) != 20 && guard < 2 * FRAME) begin
      step();
      guard++;
    end
    check("reached_idx20", lrck, 1);
    auto_en = 0; wait_cnt = 0;
    reset = 1'b0;
    model_reset();
    #1;
    check("midrst_outputs", {generate_next, bclk, lrck, sdata, overflow, underflow}, 0);
    check("midrst_fill", fill, 0);
    repeat (2) step();
    reset = 1'b1;
    step();
    check("midrst_request", generate_next, 1);
    any_hi = 0;
    while (m_n < FRAME) begin
      step();
      if (m_n < FRAME) any_hi = any_hi | sdata;
    end
    check("midrst_zero_frame", any_hi, 0);

    // ---------------- fill, backpressure, overflow ----------------
    do_reset();
    auto_en = 1; resp_left = -1; dly_min = 2; dly_max = 2;
    rand_val = 1; rand_or = 16'h8000;
    guard = 0;
    while (fill != 3'd4 && guard < 60) begin
      step();
      guard++;
    end
    check("fill_reaches_4", fill, 4);
    any_hi = 0;
    while ((m_n % FRAME) != 0 && guard < 400) begin
      if (fill == 3'd4) any_hi = any_hi | generate_next;
      step();
      guard++;
    end
    check("no_request_when_full", any_hi, 0);
    check("fill_after_pop", fill, 3);
    step();
    check("request_after_pop", generate_next, 1);
    guard = 0;
    while (fill != 3'd4 && guard < 20) begin
      step();
      guard++;
    end
    check("refill_to_4", fill, 4);
    auto_en = 0; wait_cnt = 0;
    in_ready = 1'b1;
    sample_in = 16'h1234;
    step();
    check("overflow_set", overflow, 1);
    check("overflow_fill", fill, 4);
    for (int f = 0; f < 4; f++) begin
      capture_frame(bits, lr);
      check("no_1234_sent", bits[31:16] == 16'h1234, 0);
    end
    check("overflow_sticky", overflow, 1);

    // ---------------- randomized traffic ----------------
    do_reset();
    auto_en = 1; resp_left = -1; dly_min = 1; dly_max = 6;
    rand_val = 1; rand_or = '0; stray_en = 1;
    repeat (3000) step();
    do_reset();
    auto_en = 1; resp_left = -1; dly_min = 10; dly_max = 60;
    rand_val = 1; rand_or = '0; stray_en = 0;
    repeat (3000) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sample_serializer.md
# sample_serializer

Downstream output stage of the synth audio path. It accepts 16-bit signed samples from `echo` (`out`/`out_ready`), buffers them in a small FIFO, and paces the upstream chain with a one-cycle `generate_next` request. It then serializes each sample as a mono left-justified stereo frame (bit clock, LR clock, serial data) toward the audio codec.

## Interface
- `FIFO_DEPTH`, 4: sample FIFO depth; power of two, ≥2.
- `BCLK_DIV`, 4: clk cycles per bclk half-period; ≥2.
- `clk` in 1: system clock; all logic on rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `sample_in` in 16: sample from echo `out`.
- `in_ready` in 1: one-cycle strobe from echo `out_ready`; `sample_in` is valid this cycle.
- `generate_next` out 1: one-cycle request for the next upstream sample.
- `bclk` out 1: serial bit clock.
- `lrck` out 1: 0 = left half-frame, 1 = right half-frame.
- `sdata` out 1: serial data, MSB first.
- `fill` out $clog2(FIFO_DEPTH)+1: current FIFO occupancy.
- `overflow` out 1: sticky; set when a sample is dropped.
- `underflow` out 1: sticky; set when the FIFO is empty at frame start.

## Operation
- **Reset values:**
  - `bclk`, `lrck`, `sdata`, `generate_next`, `overflow`, `underflow` = 0.
  - `fill` = 0.
  - Divider = 0, bit index = 0.
  - Shift register and held sample = 0.
- **Request logic:**
  - Flag `pending` is set when `generate_next` pulses and cleared on `in_ready`.
  - `generate_next` pulses for one cycle when `pending`=0, `fill`<FIFO_DEPTH, and `generate_next` was 0 the previous cycle.
  - At most one request is outstanding at a time.
- **Push:**
  - On `in_ready`, `sample_in` is written at the write pointer when `fill`<FIFO_DEPTH.
  - A push is also accepted when `fill`==FIFO_DEPTH if a pop occurs in the same cycle.
  - Otherwise the sample is dropped and `overflow` is set.
  - `in_ready` without `pending` is still accepted under the same rules.
- **Pointers:** wrap modulo FIFO_DEPTH.
- **Push and pop in the same cycle:** `fill` is unchanged.
- **Bit clock:**
  - The divider counts 0..BCLK_DIV-1.
  - On terminal count, `bclk` toggles and the divider returns to 0.
- **Bit index and frame:**
  - The bit index (0..31) advances on every 1→0 transition of `bclk`.
  - `lrck` = bit index[4].
  - `sdata` = shift register MSB.
  - On every falling `bclk` transition, the shift register shifts left by one (zero fill), except as noted below.
- **Frame start (index 31→0):**
  - If `fill`>0: pop the FIFO head into the held sample and the shift register.
  - If `fill`=0: reload the held sample and set `underflow`.
- **Right half (index 15→16):** reload the held sample into the shift register, so the same sample is sent on both channels.
- **Frame format:** left-justified, no one-bit delay. The MSB appears in the same bclk period in which `lrck` changes.
- **First frame after reset:** transmits zeros. The first pop occurs at the first 31→0 wrap.
- **`overflow`/`underflow`:** cleared only by reset.

## Timing
- `bclk` period = 2·BCLK_DIV clk cycles.
- Frame length = 64·BCLK_DIV clk cycles, i.e. 256 for the defaults.
- `lrck`, `sdata`, and the bit index change in the same clk edge on which `bclk` goes 1→0. They are stable across the `bclk` rising edge.
- The first `generate_next` pulse occurs in the first clk cycle after `reset` deasserts.
- FIFO write latency is 1 cycle: `fill` updates on the edge after `in_ready`.
- A sample pushed at least one cycle before a frame-start edge is popped at that edge.
- Asserting `reset` mid-frame forces all outputs and state to their reset values immediately (asynchronous). The FIFO contents are discarded.
- No combinational path from inputs to outputs.

## Test plan
- **Reset:** hold `reset`=0, then release.
  - During reset, all outputs are 0.
  - `generate_next`=1 in exactly the first cycle after release.
  - `fill`=0.
- **Single sample (BCLK_DIV=2):** answer the first request with 16'hA5C3.
  - Frame 0 is all zeros.
  - Frame 1 shows `lrck`=0 with `sdata` = 1010010111000011 MSB first, then `lrck`=1 with the same 16 bits.
  - `fill` returns to 0.
- **Fill/backpressure:** answer every request two cycles after it is issued, with no frame boundary occurring.
  - `fill` reaches 4.
  - `generate_next` stays 0 while `fill`=4.
  - After the next frame-start pop, one new request is issued.
- **Overflow:** with `fill`=4 and no pop, strobe `in_ready` with 16'h1234.
  - `overflow`=1 and `fill` stays 4.
  - 16'h1234 is never serialized.
- **Underflow:** push 16'h8001 once, then never answer requests.
  - Frame 1 sends 8001 on both channels.
  - Frame 2 repeats 8001.
  - `underflow`=1 from frame 2 start.
- **Mid-frame reset:** assert `reset` at bit index 20.
  - On the same edge, `bclk`/`lrck`/`sdata`/`fill`/flags all = 0.
  - After release, operation resumes from a zero frame.
